edge_pulser: RTL

EDGE_PULSER -- requirements
Module: edge_pulser

---
 rtl/edge_pulser_pkg.sv | 23 ++
 rtl/edge_pulser_ch.sv | 93 +++++++++
 rtl/edge_pulser.sv | 45 ++++
 3 files changed

// File: rtl/edge_pulser_pkg.sv
// Shared types and constants for the edge_pulser block.
// Debounce counter width DB_W is sized for DB_CYCLES up to 65535.
package edge_pulser_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_t;

  localparam int unsigned DB_W = 16;

  // A transition is reported when its direction is enabled by the mode.
  function automatic logic edge_hit(input edge_mode_t m, input logic f, input logic p);
    logic rise_en;
    logic fall_en;
    rise_en = (m == MODE_RISE) || (m == MODE_BOTH);
    fall_en = (m == MODE_FALL) || (m == MODE_BOTH);
    return (f & ~p & rise_en) | (~f & p & fall_en);
  endfunction

endpackage

// File: rtl/edge_pulser_ch.sv
// One edge_pulser channel: synchronizer, optional debounce, edge decode, sticky flag.
// EDGE_PULSER_DEBOUNCE_EN adds a stability counter in front of the filtered level.
module edge_pulser_ch
  import edge_pulser_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef EDGE_PULSER_DEBOUNCE_EN
  ,
  parameter int DB_CYCLES   = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       pulse,
  output logic       sticky
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   f_q, f_d;
  logic                   p_q, p_d;
  logic                   sticky_q, sticky_d;
  logic                   s;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_PULSER_DEBOUNCE_EN
  logic [DB_W-1:0] cnt_q, cnt_d;

  // f follows s only once s has disagreed for DB_CYCLES counted cycles plus the load cycle.
  always_comb begin
    cnt_d = '0;
    f_d   = f_q;
    if (s != f_q) begin
      if (cnt_q == DB_W'(DB_CYCLES)) begin
        f_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    f_d = s;
  end
`endif

  always_comb begin
    p_d      = f_q;
    pulse    = edge_hit(edge_mode_t'(mode), f_q, p_q);
    sticky_d = sticky_q;
    if (pulse) begin
      sticky_d = 1'b1;
    end else if (clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      f_q      <= 1'b0;
      p_q      <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      f_q      <= f_d;
      p_q      <= p_d;
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;

endmodule

// File: rtl/edge_pulser.sv
// Multi-channel edge detector with per-channel mode select and sticky flags.
// Define EDGE_PULSER_DEBOUNCE_EN to enable per-channel debounce of DB_CYCLES.
module edge_pulser
  import edge_pulser_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     din,
  input  logic [2*NCH-1:0]   mode,
  input  logic [NCH-1:0]     clr,
  output logic [NCH-1:0]     pulse,
  output logic [NCH-1:0]     sticky,
  output logic               any_pulse
);

  if (NCH < 1 || NCH > 32 || SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
      DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_param_err
    $error("edge_pulser: parameter out of range");
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    edge_pulser_ch #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef EDGE_PULSER_DEBOUNCE_EN
      ,
      .DB_CYCLES   (DB_CYCLES)
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .din    (din[g]),
      .mode   (mode[2*g +: 2]),
      .clr    (clr[g]),
      .pulse  (pulse[g]),
      .sticky (sticky[g])
    );
  end

  assign any_pulse = |pulse;

endmodule
